// File: rtl/motor_rodadas_param_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_rodadas_param_if
// Brief    : Bus bundle between the play engine and the UC/ROM/display side.
//            Carries start/buttons, ROM address/data, counters, score and
//            the event pulses/levels of the music-sequence game.
// Revision : 1.0 - initial release
// ============================================================================
interface motor_rodadas_param_if #(
  parameter int NUM_BOTOES = 7,
  parameter int ADDR_W     = 4,
  parameter int PONTOS_W   = 8
);
  logic                  iniciar;
  logic [NUM_BOTOES-1:0] botoes;
  logic [ADDR_W-1:0]     mem_addr;
  logic [NUM_BOTOES-1:0] mem_data;
  logic [ADDR_W-1:0]     rodada;
  logic [ADDR_W-1:0]     jogada;
  logic [3:0]            erros;
  logic [PONTOS_W-1:0]   pontos;
  logic                  nota_ok;
  logic                  nota_erro;
  logic                  fim_rodada;
  logic                  ganhou;
  logic                  perdeu;

  // Surrounding system: drives start, buttons and ROM data, observes results
  modport master (
    output iniciar, botoes, mem_data,
    input  mem_addr, rodada, jogada, erros, pontos,
    input  nota_ok, nota_erro, fim_rodada, ganhou, perdeu
  );

  // Play engine side
  modport slave (
    input  iniciar, botoes, mem_data,
    output mem_addr, rodada, jogada, erros, pontos,
    output nota_ok, nota_erro, fim_rodada, ganhou, perdeu
  );
endinterface
`default_nettype wire

// File: rtl/motor_rodadas_param.sv
`default_nettype none
// ============================================================================
// Module   : motor_rodadas_param
// Brief    : Parametrised play engine for the music-sequence game: round and
//            note counters, button edge capture, note compare against the
//            synchronous song ROM, per-note timeout, error count and score.
// Revision : 1.0 - initial release
// ============================================================================
module motor_rodadas_param #(
  parameter int NUM_BOTOES  = 7,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 500,
  parameter int MAX_ERROS   = 3,
  parameter int PONTOS_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  motor_rodadas_param_if.slave bus
);

  localparam int                  NUM_NOTAS  = 2 ** ADDR_W;
  localparam int                  TMR_W      = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0]   ULTIMA     = ADDR_W'(NUM_NOTAS - 1);
  localparam logic [3:0]          ERR_LIM    = 4'(MAX_ERROS);
  localparam logic [PONTOS_W-1:0] PONTOS_MAX = '1;

  localparam logic [2:0] S_OCIOSO  = 3'd0;
  localparam logic [2:0] S_BUSCA   = 3'd1;
  localparam logic [2:0] S_ESPERA  = 3'd2;
  localparam logic [2:0] S_COMPARA = 3'd3;
  localparam logic [2:0] S_ERRO    = 3'd4;
  localparam logic [2:0] S_FIM_ROD = 3'd5;
  localparam logic [2:0] S_FIM     = 3'd6;

  logic [2:0]            state_q,    state_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]     rodada_q,   rodada_d;
  logic [ADDR_W-1:0]     jogada_q,   jogada_d;
  logic [3:0]            erros_q,    erros_d;
  logic [PONTOS_W-1:0]   pontos_q,   pontos_d;
  logic                  ganhou_q,   ganhou_d;
  logic                  perdeu_q,   perdeu_d;
  logic [TMR_W-1:0]      timer_q,    timer_d;
  logic                  s_prev_q,   s_prev_d;
  logic [NUM_BOTOES-1:0] nota_q,     nota_d;

  logic                  w_s;
  logic                  w_press;
  logic                  w_match;
  logic [3:0]            w_erros_inc;
  logic [31:0]           w_alvo;
  logic [31:0]           w_ganho;
  logic [31:0]           w_soma;
  logic [PONTOS_W-1:0]   w_pontos_sat;

  // Button edge detect, compare and saturating score arithmetic
  always_comb begin
    w_s         = |bus.botoes;
    w_press     = w_s & ~s_prev_q;
    w_match     = (nota_q == bus.mem_data);
    w_erros_inc = erros_q + 4'd1;
    w_alvo      = 32'(rodada_q) + 32'd1;
    w_ganho     = (w_alvo > 32'(erros_q)) ? (w_alvo - 32'(erros_q)) : 32'd0;
    w_soma      = 32'(pontos_q) + w_ganho;
    w_pontos_sat = (w_soma > 32'(PONTOS_MAX)) ? PONTOS_MAX : PONTOS_W'(w_soma);
  end

  // Next-state and counter updates for the round FSM
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    erros_d    = erros_q;
    pontos_d   = pontos_q;
    ganhou_d   = ganhou_q;
    perdeu_d   = perdeu_q;
    timer_d    = timer_q;
    s_prev_d   = w_s;
    nota_d     = w_press ? bus.botoes : nota_q;

    case (state_q)
      S_OCIOSO, S_FIM: begin
        if (bus.iniciar) begin
          state_d    = S_BUSCA;
          mem_addr_d = '0;
          rodada_d   = '0;
          jogada_d   = '0;
          erros_d    = '0;
          pontos_d   = '0;
          ganhou_d   = 1'b0;
          perdeu_d   = 1'b0;
        end
      end
      S_BUSCA: begin
        // ROM word for mem_addr becomes valid during this cycle
        timer_d = '0;
        state_d = S_ESPERA;
      end
      S_ESPERA: begin
        timer_d = timer_q + TMR_W'(1);
        // A press in the final timer cycle still counts as a press
        if (w_press) begin
          state_d = S_COMPARA;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERRO;
        end
      end
      S_COMPARA: begin
        if (w_match) begin
          if (jogada_q == rodada_q) begin
            state_d = S_FIM_ROD;
          end else begin
            jogada_d   = jogada_q + ADDR_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = S_BUSCA;
          end
        end else begin
          state_d = S_ERRO;
        end
      end
      S_ERRO: begin
        erros_d = w_erros_inc;
        if (w_erros_inc == ERR_LIM) begin
          perdeu_d = 1'b1;
          state_d  = S_FIM;
        end else begin
          timer_d = '0;
          state_d = S_ESPERA;
        end
      end
      S_FIM_ROD: begin
        pontos_d = w_pontos_sat;
        if (rodada_q == ULTIMA) begin
          ganhou_d = 1'b1;
          state_d  = S_FIM;
        end else begin
          rodada_d   = rodada_q + ADDR_W'(1);
          jogada_d   = '0;
          erros_d    = '0;
          mem_addr_d = '0;
          state_d    = S_BUSCA;
        end
      end
      default: state_d = S_OCIOSO;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_OCIOSO;
      mem_addr_q <= '0;
      rodada_q   <= '0;
      jogada_q   <= '0;
      erros_q    <= '0;
      pontos_q   <= '0;
      ganhou_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      timer_q    <= '0;
      s_prev_q   <= 1'b0;
      nota_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rodada_q   <= rodada_d;
      jogada_q   <= jogada_d;
      erros_q    <= erros_d;
      pontos_q   <= pontos_d;
      ganhou_q   <= ganhou_d;
      perdeu_q   <= perdeu_d;
      timer_q    <= timer_d;
      s_prev_q   <= s_prev_d;
      nota_q     <= nota_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.rodada     = rodada_q;
  assign bus.jogada     = jogada_q;
  assign bus.erros      = erros_q;
  assign bus.pontos     = pontos_q;
  assign bus.ganhou     = ganhou_q;
  assign bus.perdeu     = perdeu_q;
  assign bus.nota_ok    = (state_q == S_COMPARA) && w_match;
  assign bus.nota_erro  = (state_q == S_ERRO);
  assign bus.fim_rodada = (state_q == S_FIM_ROD);

endmodule
`default_nettype wire
